// File: rtl/dmux_pkg.sv
// dmux_pkg: shared channel enum and default sizing for the 4-way 16-bit router
package dmux_pkg;
    typedef enum logic [1:0] {CH_W, CH_X, CH_Y, CH_Z} dmux_ch_t;
    localparam int NUM_CH     = 4;
    localparam int DMUX_WIDTH = 16;
    localparam int DMUX_DEPTH = 2;
    localparam int DMUX_CNT_W = 16;
endpackage

// File: rtl/dmux_chan_fifo.sv
// dmux_chan_fifo: per-channel FIFO with wrap-bit pointers, zero data when empty
// Ports: clk, rst_n (async active-low), push/din write side,
//        pop/dout read side (dout = head, 0 when empty), full, empty status.
module dmux_chan_fifo
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH,
    parameter int DEPTH = DMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
    logic             do_push, do_pop;
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // A full FIFO may still take a push when its head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_d    = wr_q + (AW+1)'(do_push);
    assign rd_d    = rd_q + (AW+1)'(do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/dmux4way16_router.sv
// dmux4way16_router: registered 4-way demux steering valid/ready words into per-channel FIFOs
// Ports: clk, rst_n (async active-low); IN/s/in_valid/in_ready producer side;
//        W/X/Y/Z channel heads with out_valid/out_ready per channel (bit0=W .. bit3=Z);
//        route_cnt saturating accepted-word counters, present only with DMUX_STATS_EN defined.
module dmux4way16_router
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH,
    parameter int DEPTH = DMUX_DEPTH
`ifdef DMUX_STATS_EN
    , parameter int CNT_W = DMUX_CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   IN,
    input  logic [1:0]         s,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   W,
    output logic [WIDTH-1:0]   X,
    output logic [WIDTH-1:0]   Y,
    output logic [WIDTH-1:0]   Z,
    output logic [NUM_CH-1:0]  out_valid,
    input  logic [NUM_CH-1:0]  out_ready
`ifdef DMUX_STATS_EN
    , output logic [NUM_CH*CNT_W-1:0] route_cnt
`endif
);
    logic [NUM_CH-1:0] full, empty, push, pop;
    logic [WIDTH-1:0]  dout [NUM_CH];
    dmux_ch_t          ch;
    assign ch        = dmux_ch_t'(s);
    // Depends only on s and the selected channel's state/ready, never on in_valid
    assign in_ready  = !full[s] || out_ready[s];
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign W         = dout[CH_W];
    assign X         = dout[CH_X];
    assign Y         = dout[CH_Y];
    assign Z         = dout[CH_Z];
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push[i] = in_valid && in_ready && (ch == dmux_ch_t'(i));
        dmux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .din   (IN),
            .pop   (pop[i]),
            .dout  (dout[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end
`ifdef DMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            cnt_d[i] = (push[i] && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        assign route_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif
endmodule

// File: tb/tb_dmux4way16_router.sv
// tb_dmux4way16_router: directed and random checks with a per-channel scoreboard
module tb_dmux4way16_router;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] IN;
    logic [1:0]  s;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] W, X, Y, Z;
    logic [3:0]  out_valid, out_ready;
`ifdef DMUX_STATS_EN
    logic [7:0]  route_cnt;
`endif
    int          checks = 0;
    int          errors = 0;
    logic [15:0] sbq [4][$];
    logic [15:0] dat [4];

    assign dat[0] = W;
    assign dat[1] = X;
    assign dat[2] = Y;
    assign dat[3] = Z;

    always #5 clk = ~clk;

    dmux4way16_router #(
        .WIDTH(16),
        .DEPTH(2)
`ifdef DMUX_STATS_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IN        (IN),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DMUX_STATS_EN
        , .route_cnt (route_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] sel);
        in_valid = v;
        IN       = d;
        s        = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Negedge sees the settled inputs that the next rising edge will act on
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 4; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    if (sbq[c].size() == 0) check("sb_underrun", 64'(sbq[c].size()), 64'd1);
                    else check($sformatf("sb_ch%0d", c), 64'(dat[c]), 64'(sbq[c].pop_front()));
                end
            end
            if (in_valid && in_ready) sbq[s].push_back(IN);
        end
    end

    initial begin
        int total;
        drive(1'b0, 16'h0, 2'd0);
        out_ready = 4'h0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", {W, X, Y, Z}, 64'h0);
        check("rst_ready", 64'(in_ready), 64'h1);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Basic routing, one word per channel, each visible for one cycle
        out_ready = 4'hf;
        drive(1'b1, 16'd11, 2'd0);
        #1 check("route_ready", 64'(in_ready), 64'h1);
        tick();
        check("route_v0", 64'(out_valid), 64'h1);
        check("route_W", 64'(W), 64'd11);
        drive(1'b1, 16'd2, 2'd1);
        tick();
        check("route_v1", 64'(out_valid), 64'h2);
        check("route_X", 64'(X), 64'd2);
        drive(1'b1, 16'd24, 2'd2);
        tick();
        check("route_v2", 64'(out_valid), 64'h4);
        check("route_Y", 64'(Y), 64'd24);
        drive(1'b1, 16'd8, 2'd3);
        tick();
        check("route_v3", 64'(out_valid), 64'h8);
        check("route_Z", 64'(Z), 64'd8);
        drive(1'b0, 16'h0, 2'd0);
        tick();
        check("route_idle", 64'(out_valid), 64'h0);

        // Fill X while stalled, third word refused, then drain in order
        out_ready = 4'b1101;
        drive(1'b1, 16'd5, 2'd1);
        tick();
        check("fill_X5", 64'(X), 64'd5);
        drive(1'b1, 16'd6, 2'd1);
        tick();
        drive(1'b1, 16'd7, 2'd1);
        #1 check("fill_full_ready", 64'(in_ready), 64'h0);
        tick();
        check("fill_hold_X", 64'(X), 64'd5);
        check("fill_hold_ready", 64'(in_ready), 64'h0);
        drive(1'b0, 16'h0, 2'd1);
        out_ready = 4'hf;
        tick();
        check("drain_X6", 64'(X), 64'd6);
        tick();
        check("drain_empty", 64'(out_valid), 64'h0);
        check("drain_zero", 64'(X), 64'h0);
        drive(1'b1, 16'd7, 2'd1);
        #1 check("retry_ready", 64'(in_ready), 64'h1);
        tick();
        check("retry_X7", 64'(X), 64'd7);
        drive(1'b0, 16'h0, 2'd0);
        tick();

        // Isolation: stalled full X does not block Z
        out_ready = 4'b0101;
        drive(1'b1, 16'd5, 2'd1);
        tick();
        drive(1'b1, 16'd6, 2'd1);
        tick();
        drive(1'b1, 16'h1234, 2'd3);
        #1 check("iso_ready", 64'(in_ready), 64'h1);
        tick();
        check("iso_Z", 64'(Z), 64'h1234);
        check("iso_X", 64'(X), 64'd5);
        check("iso_valid", 64'(out_valid), 64'ha);
        drive(1'b0, 16'h0, 2'd1);
        #1 check("iso_X_full", 64'(in_ready), 64'h0);

        // Full channel popped and pushed in the same cycle
        out_ready = 4'b0111;
        drive(1'b1, 16'd9, 2'd1);
        #1 check("fullpop_ready", 64'(in_ready), 64'h1);
        tick();
        check("fullpop_X6", 64'(X), 64'd6);
        out_ready = 4'b0101;
        drive(1'b0, 16'h0, 2'd1);
        #1 check("fullpop_still_full", 64'(in_ready), 64'h0);
        out_ready = 4'hf;
        tick();
        check("fullpop_X9", 64'(X), 64'd9);
        tick();
        check("fullpop_drained", 64'(out_valid), 64'h0);

        // Asynchronous reset in the middle of a burst
        out_ready = 4'h0;
        drive(1'b1, 16'ha0, 2'd0);
        tick();
        drive(1'b1, 16'hb0, 2'd2);
        tick();
        drive(1'b1, 16'hc0, 2'd0);
        tick();
        check("pre_rst_valid", 64'(out_valid), 64'h5);
        #2 rst_n = 1'b0;
        for (int c = 0; c < 4; c++) sbq[c].delete();
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_data", {W, X, Y, Z}, 64'h0);
        check("mid_rst_ready", 64'(in_ready), 64'h1);
`ifdef DMUX_STATS_EN
        check("mid_rst_cnt", 64'(route_cnt), 64'h0);
`endif
        drive(1'b0, 16'h0, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'h0);

`ifdef DMUX_STATS_EN
        // Counter saturation on a 2-bit counter
        out_ready = 4'hf;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 16'(k), 2'd0);
            tick();
            check($sformatf("cnt_W_%0d", k), 64'(route_cnt[1:0]), 64'(k > 3 ? 3 : k));
            check($sformatf("cnt_other_%0d", k), 64'(route_cnt[7:2]), 64'h0);
        end
        drive(1'b0, 16'h0, 2'd0);
        tick();
`endif

        // Random traffic checked by the scoreboard
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)));
            out_ready = 4'($urandom);
            tick();
        end
        drive(1'b0, 16'h0, 2'd0);
        out_ready = 4'hf;
        repeat (4) tick();
        total = 0;
        for (int c = 0; c < 4; c++) total += sbq[c].size();
        check("sb_drain", 64'(total), 64'h0);
        check("end_valid", 64'(out_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
